// File: rtl/bod_pkg.sv
// Shared types for the brown-out monitor: per-level debounce state and default sample width.
package bod_pkg;

  localparam int DATA_W_DEF = 20;

  typedef enum logic [1:0] {
    ST_OK           = 2'd0,
    ST_PEND_ASSERT  = 2'd1,
    ST_ACTIVE       = 2'd2,
    ST_PEND_RELEASE = 2'd3
  } bod_state_t;

  // A level counts as asserted while active or while a release is still being debounced.
  function automatic logic is_asserted(bod_state_t s);
    return (s == ST_ACTIVE) || (s == ST_PEND_RELEASE);
  endfunction

endpackage

// File: rtl/bod_level_fsm.sv
// One brown-out level: threshold/hysteresis compare plus debounce FSM.
// Exposes next-cycle status so the top can register its outputs on the same edge.
module bod_level_fsm
  import bod_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEB_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] adc_in,
  input  logic [DATA_W-1:0] thresh,
  input  logic [DATA_W-1:0] hyst,
  input  logic [DEB_W-1:0]  deb_cnt,
  output logic              active_next,
  output logic              assert_event
);

  bod_state_t        state;
  bod_state_t        state_next;
  logic [DEB_W-1:0]  cnt;
  logic [DEB_W-1:0]  cnt_next;
  logic [DEB_W-1:0]  cnt_inc;
  logic [DEB_W-1:0]  deb_eff;
  logic [DATA_W:0]   release_level;
  logic              below;
  logic              above;
  logic              qualify;

  // Sum kept one bit wider so a large hysteresis blocks release instead of wrapping.
  assign release_level = {1'b0, thresh} + {1'b0, hyst};
  assign below         = adc_in < thresh;
  assign above         = {1'b0, adc_in} >= release_level;
  assign deb_eff       = (deb_cnt == {DEB_W{1'b0}}) ? {{(DEB_W-1){1'b0}}, 1'b1} : deb_cnt;
  assign cnt_inc       = (cnt == {DEB_W{1'b1}}) ? cnt : cnt + {{(DEB_W-1){1'b0}}, 1'b1};
  assign qualify       = is_asserted(state) ? above : below;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (sample_valid) begin
      if (qualify) begin
        if (cnt_inc >= deb_eff) begin
          cnt_next   = {DEB_W{1'b0}};
          state_next = is_asserted(state) ? ST_OK : ST_ACTIVE;
        end else begin
          cnt_next   = cnt_inc;
          state_next = is_asserted(state) ? ST_PEND_RELEASE : ST_PEND_ASSERT;
        end
      end else begin
        cnt_next   = {DEB_W{1'b0}};
        state_next = is_asserted(state) ? ST_ACTIVE : ST_OK;
      end
    end else begin
      state_next = state;
      cnt_next   = cnt;
    end
  end

  assign active_next  = is_asserted(state_next);
  assign assert_event = !is_asserted(state) && (state_next == ST_ACTIVE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_OK;
      cnt   <= {DEB_W{1'b0}};
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

endmodule

// File: rtl/bod_monitor.sv
// Multi-level brown-out monitor: per-level debounce FSMs feeding a thermometer-coded
// level vector, sticky event flags and a single-cycle interrupt pulse.
module bod_monitor
  import bod_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int N_LEVELS = 2,
  parameter int DEB_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic [DATA_W-1:0]          adc_in,
  input  logic [N_LEVELS*DATA_W-1:0] thresh,
  input  logic [DATA_W-1:0]          hyst,
  input  logic [DEB_W-1:0]           deb_cnt,
  input  logic [N_LEVELS-1:0]        sticky_clr,
  output logic [N_LEVELS-1:0]        bod_level,
  output logic [N_LEVELS-1:0]        bod_sticky,
  output logic                       bod_irq
);

  logic [N_LEVELS-1:0] active_next;
  logic [N_LEVELS-1:0] assert_event;
  logic [N_LEVELS-1:0] level_thermo;

  for (genvar g = 0; g < N_LEVELS; g++) begin : g_level
    bod_level_fsm #(
      .DATA_W (DATA_W),
      .DEB_W  (DEB_W)
    ) u_fsm (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .adc_in       (adc_in),
      .thresh       (thresh[g*DATA_W +: DATA_W]),
      .hyst         (hyst),
      .deb_cnt      (deb_cnt),
      .active_next  (active_next[g]),
      .assert_event (assert_event[g])
    );
  end

  // A deeper level forces every milder level on, even with misordered thresholds.
  always_comb begin
    level_thermo = active_next;
    for (int i = N_LEVELS - 2; i >= 0; i--) begin
      level_thermo[i] = active_next[i] | level_thermo[i+1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bod_level  <= {N_LEVELS{1'b0}};
      bod_sticky <= {N_LEVELS{1'b0}};
      bod_irq    <= 1'b0;
    end else begin
      bod_level  <= level_thermo;
      bod_sticky <= (bod_sticky & ~sticky_clr) | assert_event;
      bod_irq    <= |assert_event;
    end
  end

endmodule
